// File: rtl/simple_proc_pkg.sv
// Shared constants and state type for the
// simple processor and its program loader.
package simple_proc_pkg;

  localparam int INST_ADDR_W = 5;
  localparam int INST_DATA_W = 16;
  localparam int INST_DEPTH  = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/loader_csum.sv
// XOR accumulator over the data words of an
// image, with synchronous clear and enable.
module loader_csum
  import simple_proc_pkg::*;
#(
  parameter int DATA_W = INST_DATA_W
) (
  input  logic              clk_addr,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_csum
);

  logic [DATA_W-1:0] r_csum;

  // clear wins over accumulate
  always_ff @(posedge clk_addr) begin
    if (i_clr)
      r_csum <= '0;
    else if (i_en)
      r_csum <= r_csum ^ i_data;
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/prog_mem_loader.sv
// Streams a program image into instruction
// memory and gates the processor on checksum.
module prog_mem_loader
  import simple_proc_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_DATA_W,
  parameter int DEPTH  = INST_DEPTH
) (
  input  logic              clk_addr,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              proc_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] LP_FULL =
    (ADDR_W+1)'(DEPTH);

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_run;
  logic              r_done;
  logic              r_err;

  logic              w_beat;
  logic              w_full;
  logic              w_wr;
  logic              w_reload;
  logic [DATA_W-1:0] w_csum;

  // a beat in the reset cycle is never taken
  assign in_ready = (r_state == LOAD) & ~reset;
  assign w_beat   = in_valid & in_ready;
  assign w_full   = (r_cnt == LP_FULL);
  assign w_wr     = w_beat & ~in_last & ~w_full;
  assign w_reload = reload & (r_state != LOAD);

  loader_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk_addr (clk_addr),
    .i_clr    (reset | w_reload),
    .i_en     (w_wr),
    .i_data   (in_data),
    .o_csum   (w_csum)
  );

  // load FSM with registered write port
  always_ff @(posedge clk_addr) begin
    if (reset) begin
      r_state <= LOAD;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        LOAD: begin
          if (w_beat) begin
            if (in_last) begin
              if (in_data == w_csum) begin
                r_state <= DONE;
                r_run   <= 1'b1;
                r_done  <= 1'b1;
              end else begin
                r_state <= ERR;
                r_err   <= 1'b1;
              end
            end else if (w_full) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= r_ptr;
              r_wdata <= in_data;
              r_ptr   <= r_ptr + 1'b1;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (reload) begin
            r_state <= LOAD;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  assign mem_we     = r_we;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  assign proc_run   = r_run;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_cnt;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader with
// hand-computed expected values.
module tb_prog_mem_loader;

  logic        clk_addr;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        reload;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        proc_run;
  logic        load_done;
  logic        load_err;
  logic [5:0]  word_count;

  int n_chk;
  int n_err;

  prog_mem_loader u_dut (
    .clk_addr   (clk_addr),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .proc_run   (proc_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  initial clk_addr = 1'b0;
  always #5 clk_addr = ~clk_addr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // drive one beat, step a cycle; optionally
  // check the write it produced
  task automatic send(
    input logic [15:0] d,
    input logic        last,
    input logic        wr,
    input logic [4:0]  a
  );
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk_addr);
    if (wr) begin
      check("we",    mem_we,    1'b1);
      check("waddr", mem_waddr, a);
      check("wdata", mem_wdata, d);
    end else begin
      check("we0", mem_we, 1'b0);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk_addr);
    reload = 1'b0;
    check("rl_run",   proc_run,   1'b0);
    check("rl_ready", in_ready,   1'b1);
    check("rl_cnt",   word_count, 6'd0);
    check("rl_done",  load_done,  1'b0);
    check("rl_err",   load_err,   1'b0);
  endtask

  task automatic chk_end(
    input logic       d,
    input logic       e,
    input logic [5:0] c
  );
    check("done",  load_done,  d);
    check("err",   load_err,   e);
    check("run",   proc_run,   d);
    check("ready", in_ready,   1'b0);
    check("cnt",   word_count, c);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b1;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    @(negedge clk_addr);
    @(negedge clk_addr);
    check("rst_ready", in_ready,   1'b0);
    check("rst_we",    mem_we,     1'b0);
    check("rst_addr",  mem_waddr,  5'd0);
    check("rst_data",  mem_wdata,  16'd0);
    check("rst_run",   proc_run,   1'b0);
    check("rst_done",  load_done,  1'b0);
    check("rst_err",   load_err,   1'b0);
    check("rst_cnt",   word_count, 6'd0);
    reset = 1'b0;
    #1;
    check("post_ready", in_ready, 1'b1);

    // good 3-word image
    send(16'h1234, 1'b0, 1'b1, 5'd0);
    send(16'hABCD, 1'b0, 1'b1, 5'd1);
    send(16'h0F0F, 1'b0, 1'b1, 5'd2);
    send(16'hB6F6, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b1, 1'b0, 6'd3);

    // reload ignored while reload idle
    @(negedge clk_addr);
    check("hold_done", load_done, 1'b1);

    // same words, wrong checksum
    pulse_reload();
    send(16'h1234, 1'b0, 1'b1, 5'd0);
    send(16'hABCD, 1'b0, 1'b1, 5'd1);
    send(16'h0F0F, 1'b0, 1'b1, 5'd2);
    send(16'h0000, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b0, 1'b1, 6'd3);

    // full 32-word image, XOR of 0..31 is 0
    pulse_reload();
    for (int i = 0; i < 32; i++)
      send(16'(i), 1'b0, 1'b1, 5'(i));
    send(16'h0000, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b1, 1'b0, 6'd32);

    // overflow on the 33rd data word
    pulse_reload();
    for (int i = 0; i < 32; i++)
      send(16'(i + 7), 1'b0, 1'b1, 5'(i));
    send(16'hDEAD, 1'b0, 1'b0, 5'd0);
    idle();
    chk_end(1'b0, 1'b1, 6'd32);

    // empty images
    pulse_reload();
    send(16'h0000, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b1, 1'b0, 6'd0);
    pulse_reload();
    send(16'h0001, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b0, 1'b1, 6'd0);

    // reset mid-image, then a fresh image
    pulse_reload();
    for (int i = 0; i < 5; i++)
      send(16'(i + 16'h100), 1'b0, 1'b1, 5'(i));
    idle();
    reset = 1'b1;
    @(negedge clk_addr);
    check("mid_cnt",   word_count, 6'd0);
    check("mid_ready", in_ready,   1'b0);
    reset = 1'b0;
    send(16'h0005, 1'b0, 1'b1, 5'd0);
    send(16'h0003, 1'b0, 1'b1, 5'd1);
    send(16'h0006, 1'b1, 1'b0, 5'd0);
    idle();
    chk_end(1'b1, 1'b0, 6'd2);
    pulse_reload();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
